// File: rtl/bcd_updown_scan_counter.sv
// Debounced up/down BCD counter with a multiplexed common-anode seven-segment driver.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_updown_scan_counter #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES     = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_inc,
  input  logic                    btn_dec,
  input  logic                    btn_clr,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum int {BTN_INC = 0, BTN_DEC = 1, BTN_CLR = 2} btn_e;

  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            db_q, db_d, db_prev_q;
  logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [2:0]            press;

  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic                    wrap_q, wrap_d;
  logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Debounce: state flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  always_comb begin
    logic       carry;
    logic [3:0] dig;
    logic       all9, all0;
    count_d = count_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    dig     = '0;
    all9    = 1'b1;
    all0    = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      all9 &= (count_q[4*k +: 4] == 4'd9);
      all0 &= (count_q[4*k +: 4] == 4'd0);
    end
    if (press[BTN_CLR]) begin
      count_d = '0;
    end else if (press[BTN_INC] && !press[BTN_DEC]) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig = count_q[4*k +: 4];
        if (carry) begin
          if (dig == 4'd9) begin
            count_d[4*k +: 4] = 4'd0;
          end else begin
            count_d[4*k +: 4] = dig + 4'd1;
            carry             = 1'b0;
          end
        end
      end
      wrap_d = all9;
    end else if (press[BTN_DEC] && !press[BTN_INC]) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig = count_q[4*k +: 4];
        if (carry) begin
          if (dig == 4'd0) begin
            count_d[4*k +: 4] = 4'd9;
          end else begin
            count_d[4*k +: 4] = dig - 4'd1;
            carry             = 1'b0;
          end
        end
      end
      wrap_d = all0;
    end
  end

  // Scan timing runs independently of button activity.
  always_comb begin
    logic [3:0] cur;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_above;
    logic                  zacc;
`endif
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end
    cur  = count_q[4*int'(scan_idx_q) +: 4];
    an_d = '1;
    an_d[scan_idx_q] = 1'b0;
    seg_d = seg7(cur);
`ifdef LEADING_ZERO_BLANK_EN
    zacc = 1'b1;
    zero_above = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zacc &= (count_q[4*k +: 4] == 4'd0);
      zero_above[k] = zacc;
    end
    if (scan_idx_q != '0 && zero_above[scan_idx_q]) begin
      seg_d = 7'b1111111;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      db_cnt_q   <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= 7'b1000000;
      an_q       <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    end else begin
      sync1_q    <= {btn_clr, btn_dec, btn_inc};
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      db_cnt_q   <= db_cnt_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

// File: tb/tb_bcd_updown_scan_counter.sv
// Directed bench for bcd_updown_scan_counter (2 digits, 4-cycle debounce, 2-cycle scan).
module tb_bcd_updown_scan_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_inc, btn_dec, btn_clr;
  logic [7:0] count_bcd;
  logic       wrap;
  logic [6:0] seg;
  logic [1:0] an;

  int checks = 0;
  int errors = 0;
  int wrap_cycles = 0;
  int count_changes = 0;
  logic [7:0] prev_count = 8'h00;

  bcd_updown_scan_counter #(
    .NUM_DIGITS(2), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
    .count_bcd(count_bcd), .wrap(wrap), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrap === 1'b1) wrap_cycles++;
    if (count_bcd !== prev_count) count_changes++;
    prev_count = count_bcd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic inc, input logic dec, input logic clr);
    btn_inc = inc; btn_dec = dec; btn_clr = clr;
    repeat (8) tick();
    btn_inc = 1'b0; btn_dec = 1'b0; btn_clr = 1'b0;
    repeat (8) tick();
  endtask

  logic [6:0] exp_d1_seg;

  initial begin
    rst = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0; btn_clr = 1'b0;
    repeat (2) tick();
    check("rst_count", count_bcd, 8'h00);
    check("rst_wrap", wrap, 1'b0);
    check("rst_an", an, 2'b10);
    check("rst_seg", seg, 7'b1000000);
    rst = 1'b0;

    // Idle scan: an holds each digit for two cycles.
    for (int n = 1; n <= 20; n++) begin
      tick();
      check("idle_an", an, (((n - 1) / 2) % 2 == 1) ? 2'b01 : 2'b10);
      check("idle_seg", seg, 7'b1000000);
    end
    check("idle_count", count_bcd, 8'h00);

    wrap_cycles = 0;
    for (int r = 0; r < 10; r++) begin
      btn_inc = 1'b1; repeat (3) tick();
      btn_inc = 1'b0; tick();
    end
    repeat (10) tick();
    check("bounce_count", count_bcd, 8'h00);

    count_changes = 0;
    for (int r = 0; r < 12; r++) press(1'b1, 1'b0, 1'b0);
    check("inc12_count", count_bcd, 8'h12);
    check("inc12_steps", count_changes, 12);
    check("inc12_nowrap", wrap_cycles, 0);

    for (int r = 0; r < 87; r++) press(1'b1, 1'b0, 1'b0);
    check("at_99", count_bcd, 8'h99);
    check("to99_nowrap", wrap_cycles, 0);
    press(1'b1, 1'b0, 1'b0);
    check("wrap_up_count", count_bcd, 8'h00);
    check("wrap_up_pulse", wrap_cycles, 1);
    press(1'b0, 1'b1, 1'b0);
    check("wrap_dn_count", count_bcd, 8'h99);
    check("wrap_dn_pulse", wrap_cycles, 2);

    for (int r = 0; r < 54; r++) press(1'b0, 1'b1, 1'b0);
    check("dec_to_45", count_bcd, 8'h45);
    count_changes = 0;
    press(1'b1, 1'b1, 1'b0);
    check("incdec_hold", count_bcd, 8'h45);
    check("incdec_nochange", count_changes, 0);
    press(1'b1, 1'b0, 1'b1);
    check("clr_wins", count_bcd, 8'h00);
    check("clr_nowrap", wrap_cycles, 2);

    for (int r = 0; r < 7; r++) press(1'b1, 1'b0, 1'b0);
    check("at_07", count_bcd, 8'h07);
`ifdef LEADING_ZERO_BLANK_EN
    exp_d1_seg = 7'b1111111;
`else
    exp_d1_seg = 7'b1000000;
`endif
    for (int n = 0; n < 4; n++) begin
      tick();
      if (an == 2'b01) check("d1_seg", seg, exp_d1_seg);
      else             check("d0_seg", seg, 7'b1111000);
    end

    // Reset lands while an increment is still being debounced.
    btn_inc = 1'b1;
    repeat (4) tick();
    rst = 1'b1; btn_inc = 1'b0;
    tick();
    check("midrst_count", count_bcd, 8'h00);
    check("midrst_wrap", wrap, 1'b0);
    check("midrst_an", an, 2'b10);
    check("midrst_seg", seg, 7'b1000000);
    rst = 1'b0;
    repeat (16) tick();
    check("postrst_count", count_bcd, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_updown_scan_counter.md
Name: bcd_updown_scan_counter

Overview:
- Parametrised successor to the single-digit button counter.
- Takes raw increment, decrement and clear buttons and debounces them internally.
- Converts each debounced press into a single-cycle event and drives a NUM_DIGITS-wide BCD up/down counter with wrap in both directions.
- Time-multiplexes the count onto a common-anode seven-segment bank through active-low anode and segment lines.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and display anodes (1..8).
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a raw button must differ from its debounced state before the state flips (>=2).
- SCAN_CYCLES, 100000, clk cycles each digit stays lit before the scan advances (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_inc  in  1  raw increment button, active-high, asynchronous to clk.
- btn_dec  in  1  raw decrement button, active-high, asynchronous to clk.
- btn_clr  in  1  raw clear button, active-high, asynchronous to clk.
- count_bcd  out  4*NUM_DIGITS  current count; digit k in bits [4k+3:4k]; digit 0 = least significant.
- wrap  out  1  one-cycle pulse when a step wraps, either all-9s->0 or 0->all-9s.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- an  out  NUM_DIGITS  active-low anode enables; exactly one bit low at all times.

Behaviour:
- Reset (rst=1 at a clk edge) clears all state:
  - debounced states=0; debounce counters=0; edge registers=0;
  - count_bcd=0; wrap=0; scan index=0; scan counter=0;
  - an = all ones except bit0=0; seg = 7'b1000000.
  - rst overrides any in-progress debounce or press.
- Input sync: each raw button passes through a 2-flop synchroniser before debouncing.
- Debounce, per button:
  - If the synced input equals the debounced state, the counter goes to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 the debounced state takes the input value and the counter goes to 0.
  - A single-cycle glitch never propagates.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Edge detect: a press event is a one-cycle pulse on the 0->1 transition of a debounced state. Releases produce no event. A held button produces exactly one event.
- Counter update, registered one cycle after the press event. Priority per cycle:
  - clr event: count_bcd=0, wrap=0.
  - inc and dec events in the same cycle: no change.
  - inc event:
    - BCD ripple add; a digit at 9 becomes 0 and carries.
    - If all digits are 9, the result is all 0 and wrap=1.
  - dec event:
    - BCD ripple subtract; a digit at 0 becomes 9 and borrows.
    - If all digits are 0, the result is all 9 and wrap=1.
  - Otherwise no change.
  - wrap is high only in the cycle count_bcd takes the wrapped value.
- count_bcd digits never hold 10..15.
- Scan:
  - The scan counter counts 0..SCAN_CYCLES-1.
  - At terminal count the scan index advances, wrapping from NUM_DIGITS-1 to 0.
  - an and seg are registered together, so they always belong to the same digit. They update one cycle after the index changes.
- Segment encoding, digits 0-9:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other value = 1111111.
- Buttons pressed during scanning do not disturb scan timing.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: while digit k is displayed, seg=1111111 if digit k and every more-significant digit are 0. Digit 0 is never blanked, so count 0 shows a single "0". count_bcd is unaffected.
- Undefined: every digit is always displayed, including leading zeros.

Test Plan (NUM_DIGITS=2, DEBOUNCE_CYCLES=4, SCAN_CYCLES=2):
- Reset, then idle 20 cycles -> count_bcd=8'h00.
  - an alternates 2'b10/2'b01 every 2 cycles.
  - seg=1000000 throughout (macro undefined).
- Hold btn_inc for 3 cycles, then 1 cycle low, repeated 10 times -> count_bcd stays 8'h00 (bounce rejected).
- 12 clean presses of btn_inc (8 cycles high, 8 low) -> count_bcd=8'h12; exactly 12 increments; wrap never asserted.
- From 8'h99, one inc press -> count_bcd=8'h00 with wrap=1 for exactly one cycle. A subsequent dec press -> 8'h99 with wrap pulse.
- btn_inc and btn_dec pressed on the same cycles from 8'h45 -> count_bcd remains 8'h45. btn_clr together with btn_inc -> 8'h00.
- With LEADING_ZERO_BLANK_EN defined and count 8'h07 -> digit1 seg=1111111, digit0 seg=1111000. Pulsing rst mid-debounce -> all outputs return to their reset values on the next edge.
